// File: rtl/mix_pkg.sv
// mix_pkg: shared types and constants for the mix_engine lane mixer.
// Holds the FSM state enum, the per-lane MUL table, the ADD rule and the shift rule.
package mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MUL [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

  function automatic int mul_of(input int i);
    return MUL[i % 8];
  endfunction

  function automatic int add_of(input int i);
    return 2 * i + 1;
  endfunction

  function automatic int shl_of(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/mix_round.sv
// mix_round: one combinational mixing round over LANES lanes of WIDTH bits.
// Ports: lanes_i (packed input lanes), lanes_o (packed mixed lanes).
module mix_round
  import mix_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 32
) (
  input  logic [LANES*WIDTH-1:0] lanes_i,
  output logic [LANES*WIDTH-1:0] lanes_o
);

  localparam int SHL = shl_of(WIDTH);

  always_comb begin : round
    logic [WIDTH-1:0] x [LANES];
    for (int i = 0; i < LANES; i++)
      x[i] = lanes_i[i*WIDTH +: WIDTH];
    for (int i = 0; i < LANES; i++)
      x[i] = x[i] + WIDTH'(i);
    // Steps 2 and 3 chain: each lane sees lanes already
    // rewritten earlier in the same step.
    for (int i = 0; i < LANES; i++)
      x[i] = x[i] + x[(i + LANES - 1) % LANES];
    for (int i = 0; i < LANES; i++)
      x[i] = x[i] ^ (x[(i + 3) % LANES] << SHL);
    for (int i = 0; i < LANES; i++)
      x[i] = x[i] * WIDTH'(mul_of(i)) + WIDTH'(add_of(i));
    lanes_o = '0;
    for (int i = 0; i < LANES; i++)
      lanes_o[i*WIDTH +: WIDTH] = x[i];
  end

endmodule

// File: rtl/mix_engine.sv
// mix_engine: iterates mix_round r times over a seed, valid/ready on both sides.
// Ports: clk, rst (sync high), in_valid/in_ready/in_seed/in_rounds, out_valid/out_ready/out_state; abort with MIX_ENGINE_ABORT_EN.
module mix_engine
  import mix_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef MIX_ENGINE_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_seed,
  input  logic [7:0]             in_rounds,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_state
);

  state_e                 state_q, state_d;
  logic [LANES*WIDTH-1:0] x_q, x_d;
  logic [LANES*WIDTH-1:0] x_rnd;
  logic [7:0]             cnt_q, cnt_d;

  mix_round #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) u_round (
    .lanes_i(x_q),
    .lanes_o(x_rnd)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_seed;
          cnt_d   = in_rounds;
          state_d = (in_rounds == 8'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        x_d   = x_rnd;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef MIX_ENGINE_ABORT_EN
    // Abort drops the job but leaves the lanes as they were.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      x_d     = x_q;
      cnt_d   = 8'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_state = x_q;

endmodule

// File: tb/tb_mix_engine.sv
// tb_mix_engine: directed checks of mix_engine in a 2x8 and a default 8x32 build.
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_mix_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s_in_valid = 1'b0, s_in_ready, s_out_valid;
  logic         s_out_ready = 1'b0;
  logic [15:0]  s_seed = '0, s_out_state;
  logic [7:0]   s_rounds = '0;

  logic         d_in_valid = 1'b0, d_in_ready, d_out_valid;
  logic         d_out_ready = 1'b0;
  logic [255:0] d_seed = '0, d_out_state;
  logic [7:0]   d_rounds = '0;

`ifdef MIX_ENGINE_ABORT_EN
  logic s_abort = 1'b0;
  logic d_abort = 1'b0;
`endif

  mix_engine #(.LANES(2), .WIDTH(8)) u_small (
    .clk(clk),
    .rst(rst),
`ifdef MIX_ENGINE_ABORT_EN
    .abort(s_abort),
`endif
    .in_valid(s_in_valid),
    .in_ready(s_in_ready),
    .in_seed(s_seed),
    .in_rounds(s_rounds),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_state(s_out_state)
  );

  mix_engine u_dflt (
    .clk(clk),
    .rst(rst),
`ifdef MIX_ENGINE_ABORT_EN
    .abort(d_abort),
`endif
    .in_valid(d_in_valid),
    .in_ready(d_in_ready),
    .in_seed(d_seed),
    .in_rounds(d_rounds),
    .out_valid(d_out_valid),
    .out_ready(d_out_ready),
    .out_state(d_out_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] s,
                                         input int r);
    logic [31:0]  x [8];
    int           mul [8];
    logic [255:0] o;
    mul = '{3, 5, 7, 11, 13, 17, 19, 23};
    for (int i = 0; i < 8; i++) x[i] = s[i*32 +: 32];
    repeat (r) begin
      for (int i = 0; i < 8; i++) x[i] = x[i] + 32'(i);
      for (int i = 0; i < 8; i++) x[i] = x[i] + x[(i + 7) % 8];
      for (int i = 0; i < 8; i++)
        x[i] = x[i] ^ {x[(i + 3) % 8][15:0], 16'h0000};
      for (int i = 0; i < 8; i++)
        x[i] = x[i] * 32'(mul[i]) + 32'(2 * i + 1);
    end
    for (int i = 0; i < 8; i++) o[i*32 +: 32] = x[i];
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called just after a falling edge with the DUT idle; returns with
  // out_valid high (or the budget spent) and the result not yet taken.
  task automatic d_run(input logic [255:0] seed, input logic [7:0] r,
                       output int edges, output logic busy_rdy);
    d_seed = seed;
    d_rounds = r;
    d_in_valid = 1'b1;
    busy_rdy = 1'b0;
    @(negedge clk);
    d_in_valid = 1'b0;
    d_seed = ~seed;
    d_rounds = ~r;
    edges = 1;
    while (!d_out_valid && edges < 600) begin
      busy_rdy = busy_rdy | d_in_ready;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic d_take();
    d_out_ready = 1'b1;
    @(negedge clk);
    d_out_ready = 1'b0;
    chk("d_take_ready", 256'(d_in_ready), 256'd1);
  endtask

  task automatic s_run(input logic [15:0] seed, input logic [7:0] r,
                       output int edges);
    s_seed = seed;
    s_rounds = r;
    s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    s_seed = ~seed;
    edges = 1;
    while (!s_out_valid && edges < 600) begin
      @(negedge clk);
      edges++;
    end
  endtask

  int           e;
  logic         br;
  logic [255:0] sd, snap;
  logic         flag_v, flag_r, flag_s;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_d_ready", 256'(d_in_ready), 256'd1);
    chk("rst_d_valid", 256'(d_out_valid), 256'd0);
    chk("rst_d_state", d_out_state, 256'd0);
    chk("rst_s_ready", 256'(s_in_ready), 256'd1);
    chk("rst_s_valid", 256'(s_out_valid), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Small build, hand-computed single rounds.
    s_run(16'h0000, 8'd1, e);
    chk("s_zero_lat", 256'(e), 256'd2);
    chk("s_zero_state", 256'(s_out_state), 256'h5D64);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    chk("s_zero_back_idle", 256'(s_in_ready), 256'd1);
    s_run(16'h0001, 8'd1, e);
    chk("s_one_lat", 256'(e), 256'd2);
    chk("s_one_state", 256'(s_out_state), 256'hB297);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;

    // Zero rounds passes the seed straight through.
    sd = rnd256();
    d_run(sd, 8'd0, e, br);
    chk("r0_lat", 256'(e), 256'd1);
    chk("r0_state", d_out_state, sd);
    d_take();

    // Full 255-round run against the model.
    sd = rnd256();
    d_run(sd, 8'd255, e, br);
    chk("r255_lat", 256'(e), 256'd256);
    chk("r255_busy_ready", 256'(br), 256'd0);
    chk("r255_state", d_out_state, model(sd, 255));
    d_take();

    // Backpressure in DONE with a competing offer.
    sd = rnd256();
    d_run(sd, 8'd2, e, br);
    chk("bp_lat", 256'(e), 256'd3);
    snap = d_out_state;
    chk("bp_state", snap, model(sd, 2));
    d_seed = rnd256();
    d_rounds = 8'd1;
    d_in_valid = 1'b1;
    flag_v = 1'b1;
    flag_r = 1'b0;
    flag_s = 1'b1;
    repeat (10) begin
      @(negedge clk);
      flag_v = flag_v & d_out_valid;
      flag_r = flag_r | d_in_ready;
      flag_s = flag_s & (d_out_state == snap);
    end
    d_in_valid = 1'b0;
    chk("bp_valid_held", 256'(flag_v), 256'd1);
    chk("bp_no_accept", 256'(flag_r), 256'd0);
    chk("bp_state_held", 256'(flag_s), 256'd1);
    d_take();
    chk("bp_valid_drop", 256'(d_out_valid), 256'd0);

    // Reset with cnt=5 in RUN, then a fresh job.
    d_seed = rnd256();
    d_rounds = 8'd10;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 256'(d_in_ready), 256'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 256'(d_in_ready), 256'd1);
    chk("mid_rst_valid", 256'(d_out_valid), 256'd0);
    chk("mid_rst_state", d_out_state, 256'd0);
    sd = rnd256();
    d_run(sd, 8'd3, e, br);
    chk("post_rst_lat", 256'(e), 256'd4);
    chk("post_rst_state", d_out_state, model(sd, 3));
    d_take();

`ifdef MIX_ENGINE_ABORT_EN
    d_seed = rnd256();
    d_rounds = 8'd10;
    d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    snap = d_out_state;
    d_abort = 1'b1;
    @(negedge clk);
    d_abort = 1'b0;
    chk("abort_ready", 256'(d_in_ready), 256'd1);
    chk("abort_valid", 256'(d_out_valid), 256'd0);
    chk("abort_state", d_out_state, snap);
    flag_v = 1'b0;
    repeat (12) begin
      @(negedge clk);
      flag_v = flag_v | d_out_valid;
    end
    chk("abort_no_result", 256'(flag_v), 256'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
